// File: rtl/bcd_to_excess3_serial_if.sv
// Serial BCD-to-Excess-3 converter bus: serial bit in; serial code, parallel digit and status out.
interface bcd_to_excess3_serial_if #(
  parameter int unsigned CNT_W = 8
);
  logic             X;
  logic             Z;
  logic [3:0]       Dout;
  logic             Done;
  logic             Err;
  logic [CNT_W-1:0] DigitCnt;

  modport master (output X, input Z, Dout, Done, Err, DigitCnt);
  modport slave  (input X, output Z, Dout, Done, Err, DigitCnt);
endinterface

// File: rtl/bcd_to_excess3_serial.sv
// Serial BCD-to-Excess-3 encoder: adds 0011 to an LSB-first BCD digit with a Mealy output,
// and reports each completed digit in parallel with a range flag and a wrapping digit count.
module bcd_to_excess3_serial #(
  parameter bit          CHECK_RANGE = 1'b1,
  parameter int unsigned CNT_W       = 8
) (
  input  logic                      Clk,
  input  logic                      Rst,
  bcd_to_excess3_serial_if.slave    bus
);

  typedef enum logic [2:0] {
    S0   = 3'd0,
    S1C0 = 3'd1,
    S1C1 = 3'd2,
    S2C0 = 3'd3,
    S2C1 = 3'd4,
    S3C0 = 3'd5,
    S3C1 = 3'd6
  } state_e;

  state_e           state_q, state_d;
  logic [2:0]       sh_q;
  logic             flag_q, flag_d;
  logic [3:0]       dout_q;
  logic             done_q;
  logic             err_q;
  logic [CNT_W-1:0] cnt_q;

  logic             x;
  logic             z_c;
  logic             last_c;
  logic             err_d;

  assign x = bus.X;

  // Bit index and carry live in the state; Z is the sum bit of X + 0011 at that position.
  always_comb begin
    state_d = S0;
    z_c     = 1'b0;
    flag_d  = flag_q;
    last_c  = 1'b0;
    unique case (state_q)
      S0: begin
        z_c     = ~x;
        state_d = x ? S1C1 : S1C0;
      end
      S1C0: begin
        z_c     = ~x;
        flag_d  = x;
        state_d = x ? S2C1 : S2C0;
      end
      S1C1: begin
        z_c     = x;
        flag_d  = x;
        state_d = S2C1;
      end
      S2C0: begin
        z_c     = x;
        flag_d  = flag_q | x;
        state_d = S3C0;
      end
      S2C1: begin
        z_c     = ~x;
        flag_d  = flag_q | x;
        state_d = x ? S3C1 : S3C0;
      end
      S3C0: begin
        z_c     = x;
        last_c  = 1'b1;
        state_d = S0;
      end
      S3C1: begin
        z_c     = ~x;
        last_c  = 1'b1;
        state_d = S0;
      end
      default: begin
        z_c     = 1'b0;
        state_d = S0;
      end
    endcase
  end

  // Digit > 9 means bit3 set together with bit1 or bit2.
  assign err_d = last_c & CHECK_RANGE & x & flag_q;

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_q <= S0;
      sh_q    <= 3'b000;
      flag_q  <= 1'b0;
      dout_q  <= 4'b0000;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sh_q    <= {z_c, sh_q[2:1]};
      flag_q  <= flag_d;
      done_q  <= last_c;
      err_q   <= err_d;
      if (last_c) begin
        dout_q <= {z_c, sh_q};
        cnt_q  <= cnt_q + CNT_W'(1);
      end
    end
  end

  assign bus.Z        = Rst & z_c;
  assign bus.Dout     = dout_q;
  assign bus.Done     = done_q;
  assign bus.Err      = err_q;
  assign bus.DigitCnt = cnt_q;

endmodule

// File: tb/tb_bcd_to_excess3_serial.sv
// Directed bench for bcd_to_excess3_serial: default build, range check disabled, and 2-bit counter
// instances all receive the same serial stream.
module tb_bcd_to_excess3_serial;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic x_drv = 1'b0;

  int n_assert = 0;
  int n_fail   = 0;

  logic       pend = 1'b0;
  logic [3:0] pend_dout = 4'h0;
  logic       pend_err = 1'b0;
  int         cnt8 = 0;
  int         cnt2 = 0;

  always #5 clk = ~clk;

  bcd_to_excess3_serial_if #(.CNT_W(8)) bus_a ();
  bcd_to_excess3_serial_if #(.CNT_W(8)) bus_n ();
  bcd_to_excess3_serial_if #(.CNT_W(2)) bus_c ();

  assign bus_a.X = x_drv;
  assign bus_n.X = x_drv;
  assign bus_c.X = x_drv;

  bcd_to_excess3_serial #(.CHECK_RANGE(1'b1), .CNT_W(8)) dut (
    .Clk(clk), .Rst(rst), .bus(bus_a)
  );
  bcd_to_excess3_serial #(.CHECK_RANGE(1'b0), .CNT_W(8)) dut_nc (
    .Clk(clk), .Rst(rst), .bus(bus_n)
  );
  bcd_to_excess3_serial #(.CHECK_RANGE(1'b1), .CNT_W(2)) dut_c2 (
    .Clk(clk), .Rst(rst), .bus(bus_c)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Checks the completion of the previously sent digit, or the absence of a Done pulse.
  task automatic check_done();
    if (pend) begin
      cnt8 = (cnt8 + 1) % 256;
      cnt2 = (cnt2 + 1) % 4;
      chk("Done", 8'(bus_a.Done), 8'd1);
      chk("Dout", 8'(bus_a.Dout), 8'(pend_dout));
      chk("Err", 8'(bus_a.Err), 8'(pend_err));
      chk("DigitCnt", bus_a.DigitCnt, 8'(cnt8));
      chk("Dout_nc", 8'(bus_n.Dout), 8'(pend_dout));
      chk("Err_nc", 8'(bus_n.Err), 8'd0);
      chk("DigitCnt_w2", 8'(bus_c.DigitCnt), 8'(cnt2));
      pend = 1'b0;
    end else begin
      chk("Done_idle", 8'(bus_a.Done), 8'd0);
    end
  endtask

  // Called 1 time unit after a posedge; returns at the same phase after the digit-complete edge.
  task automatic send_digit(input logic [3:0] d, input logic [3:0] e3, input logic er);
    for (int i = 0; i < 4; i++) begin
      x_drv = d[i];
      @(negedge clk);
      chk($sformatf("Z d%0h b%0d", d, i), 8'(bus_a.Z), 8'(e3[i]));
      if (i == 0) check_done();
      else chk($sformatf("Done_mid d%0h b%0d", d, i), 8'(bus_a.Done), 8'd0);
      @(posedge clk);
      #1;
    end
    pend      = 1'b1;
    pend_dout = e3;
    pend_err  = er;
  endtask

  // Collects the last digit, then asserts reset mid-cycle and checks the asynchronous clear.
  task automatic finish_group();
    x_drv = 1'b0;
    @(negedge clk);
    check_done();
    #1 rst = 1'b0;
    #1;
    chk("rst_Z", 8'(bus_a.Z), 8'd0);
    chk("rst_Dout", 8'(bus_a.Dout), 8'd0);
    chk("rst_Done", 8'(bus_a.Done), 8'd0);
    chk("rst_Err", 8'(bus_a.Err), 8'd0);
    chk("rst_DigitCnt", bus_a.DigitCnt, 8'd0);
    chk("rst_DigitCnt_w2", 8'(bus_c.DigitCnt), 8'd0);
    cnt8 = 0;
    cnt2 = 0;
    pend = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
  endtask

  initial begin
    rst   = 1'b0;
    x_drv = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("init_Z", 8'(bus_a.Z), 8'd0);
    chk("init_Dout", 8'(bus_a.Dout), 8'd0);
    chk("init_Done", 8'(bus_a.Done), 8'd0);
    chk("init_Err", 8'(bus_a.Err), 8'd0);
    chk("init_DigitCnt", bus_a.DigitCnt, 8'd0);
    rst = 1'b1;

    // Valid BCD sweep, back to back
    send_digit(4'h0, 4'h3, 1'b0);
    send_digit(4'h1, 4'h4, 1'b0);
    send_digit(4'h2, 4'h5, 1'b0);
    send_digit(4'h3, 4'h6, 1'b0);
    send_digit(4'h4, 4'h7, 1'b0);
    send_digit(4'h5, 4'h8, 1'b0);
    send_digit(4'h6, 4'h9, 1'b0);
    send_digit(4'h7, 4'hA, 1'b0);
    send_digit(4'h8, 4'hB, 1'b0);
    send_digit(4'h9, 4'hC, 1'b0);
    x_drv = 1'b0;
    @(negedge clk);
    check_done();
    chk("sweep_DigitCnt", bus_a.DigitCnt, 8'd10);
    chk("sweep_DigitCnt_w2", 8'(bus_c.DigitCnt), 8'd2);
    @(posedge clk);
    #1;
    pend = 1'b0;
    finish_group();

    // Non-BCD codes convert modulo 16 and raise Err
    send_digit(4'hA, 4'hD, 1'b1);
    send_digit(4'hB, 4'hE, 1'b1);
    send_digit(4'hC, 4'hF, 1'b1);
    send_digit(4'hD, 4'h0, 1'b1);
    send_digit(4'hE, 4'h1, 1'b1);
    send_digit(4'hF, 4'h2, 1'b1);
    send_digit(4'h9, 4'hC, 1'b0);
    finish_group();

    // Back to back 0111 then 0010
    send_digit(4'h7, 4'hA, 1'b0);
    send_digit(4'h2, 4'h5, 1'b0);
    finish_group();

    // Partial 0110 abandoned by reset, then a full 0001
    x_drv = 1'b0;
    @(negedge clk);
    chk("part_Z_b0", 8'(bus_a.Z), 8'd1);
    @(posedge clk);
    #1 x_drv = 1'b1;
    @(negedge clk);
    chk("part_Z_b1", 8'(bus_a.Z), 8'd0);
    chk("part_Done", 8'(bus_a.Done), 8'd0);
    #1 rst = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
    send_digit(4'h1, 4'h4, 1'b0);
    x_drv = 1'b0;
    @(negedge clk);
    check_done();
    chk("part_DigitCnt", bus_a.DigitCnt, 8'd1);
    chk("part_Dout", 8'(bus_a.Dout), 8'h4);
    finish_group();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
